// File: rtl/key_repeat_controller_pkg.sv
// key_repeat_controller_pkg
// Purpose : Definitions shared by the key repeat controller and its timer.
//           Holds the FSM state encoding, the common HIGH/LOW level constants
//           and a constant function for sizing the shared cycle counter.
// Contents:
//   state_t    - 3-bit FSM state encoding (IDLE .. RELEASE_DB)
//   HIGH / LOW - key level constants (HIGH = pressed)
//   max3()     - largest of three integers, usable at elaboration time
package key_repeat_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DB    = 3'd1,
    HOLD_DELAY  = 3'd2,
    HOLD_REPEAT = 3'd3,
    RELEASE_DB  = 3'd4
  } state_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // The one counter is reused for debounce, repeat delay and repeat rate,
  // so it has to be wide enough for the largest of the three limits.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_repeat_controller_timer.sv
// key_cycle_timer
// Purpose : Loadable up-counter with synchronous clear, load and enable,
//           plus a terminal-count flag compared against a run-time limit.
// Ports   :
//   clk        in   clock, counts on the rising edge
//   reset_low  in   asynchronous active-low reset (count -> 0)
//   clear      in   count <= 0 (highest priority)
//   load       in   count <= load_value
//   enable     in   count <= count + 1, saturating at all-ones
//   load_value in   value taken on load
//   limit      in   terminal-count target for the current phase
//   terminal   out  HIGH when the sample taken this cycle is the limit-th one,
//                   i.e. count + 1 == limit
module key_cycle_timer
  import key_repeat_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   next_count;

  // The extra top bit of next_count is the carry out; it doubles as the
  // saturation guard and keeps a zero limit from ever matching.
  assign next_count = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign terminal   = (next_count == {1'b0, limit});

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !next_count[WIDTH]) begin
      count <= next_count[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/key_repeat_controller.sv
// key_repeat_controller
// Purpose : Turns one synchronised raw key level into clean key events:
//           debounced press and release pulses, auto-repeat pulses while the
//           key is held, and a debounced held level. All outputs registered.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive equal samples to accept a press/release (>=1)
//   REPEAT_DELAY     cycles from press pulse to first repeat (0 = no repeat)
//   REPEAT_RATE      cycles between later repeat pulses (>=1)
// Ports   :
//   clk            in   system clock
//   reset_low      in   asynchronous active-low reset
//   level          in   synchronised key level, HIGH = pressed
//   held           out  debounced key state
//   press          out  one-cycle pulse when a press is accepted
//   repeat_pulse   out  one-cycle pulse per auto-repeat tick
//   release_pulse  out  one-cycle pulse when a release is accepted
//   any_event      out  press | repeat_pulse | release_pulse
module key_repeat_controller
  import key_repeat_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_RATE     = 100
) (
  input  logic clk,
  input  logic reset_low,
  input  logic level,
  output logic held,
  output logic press,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic any_event
);

  localparam int MAX_LIMIT = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam int CW        = $clog2(MAX_LIMIT + 1);

  localparam logic [CW-1:0] DB_LIMIT    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DELAY_LIMIT = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_LIMIT  = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] FIRST_SAMPLE = CW'(1);

  // With a one-sample debounce the first differing sample is already the
  // accepting one, so the debounce states are skipped entirely.
  localparam bit DB_ONE     = (DEBOUNCE_CYCLES == 1);
  localparam bit REPEAT_ON  = (REPEAT_DELAY != 0);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_RATE < 1 || REPEAT_DELAY < 0) begin : g_param_error
    $error("key_repeat_controller: DEBOUNCE_CYCLES and REPEAT_RATE must be >= 1, REPEAT_DELAY >= 0");
  end

  state_t        state;
  logic [CW-1:0] limit;
  logic          timer_clear;
  logic          timer_load;
  logic          timer_enable;
  logic          terminal;

  key_cycle_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk        (clk),
    .reset_low  (reset_low),
    .clear      (timer_clear),
    .load       (timer_load),
    .enable     (timer_enable),
    .load_value (FIRST_SAMPLE),
    .limit      (limit),
    .terminal   (terminal)
  );

  // Timer control follows the same decisions as the FSM below: the first
  // sample of a debounce window loads 1, each further matching sample
  // counts, and every accepted event or abandoned window clears to 0.
  always_comb begin
    limit        = DB_LIMIT;
    timer_clear  = 1'b0;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    case (state)
      IDLE: begin
        if (level == HIGH && !DB_ONE) timer_load  = 1'b1;
        else                          timer_clear = 1'b1;
      end
      PRESS_DB: begin
        if (level == HIGH && !terminal) timer_enable = 1'b1;
        else                            timer_clear  = 1'b1;
      end
      HOLD_DELAY: begin
        limit = DELAY_LIMIT;
        if (level == LOW) begin
          if (DB_ONE) timer_clear = 1'b1;
          else        timer_load  = 1'b1;
        end else if (REPEAT_ON) begin
          if (terminal) timer_clear  = 1'b1;
          else          timer_enable = 1'b1;
        end
      end
      HOLD_REPEAT: begin
        limit = RATE_LIMIT;
        if (level == LOW) begin
          if (DB_ONE) timer_clear = 1'b1;
          else        timer_load  = 1'b1;
        end else if (terminal) begin
          timer_clear = 1'b1;
        end else begin
          timer_enable = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (level == LOW && !terminal) timer_enable = 1'b1;
        else                           timer_clear  = 1'b1;
      end
      default: begin
        timer_clear = 1'b1;
      end
    endcase
  end

  // Main FSM with registered outputs. Pulses default low every cycle so
  // each one lasts exactly one clock, and only one branch can raise a pulse
  // in a given cycle, which keeps press/repeat/release mutually exclusive.
  // A bounce back to HIGH during release debounce returns to HOLD_DELAY so
  // the repeat delay restarts in full rather than resuming the old cadence.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state         <= IDLE;
      held          <= 1'b0;
      press         <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      any_event     <= 1'b0;
    end else begin
      press         <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      any_event     <= 1'b0;
      case (state)
        IDLE: begin
          if (level == HIGH) begin
            if (DB_ONE) begin
              state     <= HOLD_DELAY;
              held      <= 1'b1;
              press     <= 1'b1;
              any_event <= 1'b1;
            end else begin
              state <= PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (level == LOW) begin
            state <= IDLE;
          end else if (terminal) begin
            state     <= HOLD_DELAY;
            held      <= 1'b1;
            press     <= 1'b1;
            any_event <= 1'b1;
          end
        end
        HOLD_DELAY, HOLD_REPEAT: begin
          if (level == LOW) begin
            if (DB_ONE) begin
              state         <= IDLE;
              held          <= 1'b0;
              release_pulse <= 1'b1;
              any_event     <= 1'b1;
            end else begin
              state <= RELEASE_DB;
            end
          end else if (terminal && (state == HOLD_REPEAT || REPEAT_ON)) begin
            state        <= HOLD_REPEAT;
            repeat_pulse <= 1'b1;
            any_event    <= 1'b1;
          end
        end
        RELEASE_DB: begin
          if (level == HIGH) begin
            state <= HOLD_DELAY;
          end else if (terminal) begin
            state         <= IDLE;
            held          <= 1'b0;
            release_pulse <= 1'b1;
            any_event     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeat_controller.sv
// tb_key_repeat_controller
// Purpose : Self-checking bench for key_repeat_controller with
//           DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, plus a second
//           instance with REPEAT_DELAY=0. Level is driven on the falling edge
//           and outputs are sampled 1 time unit after the rising edge.
module tb_key_repeat_controller;

  logic clk;
  logic reset_low;
  logic level;
  logic level_nr;

  logic held, press, repeat_pulse, release_pulse, any_event;
  logic held_nr, press_nr, repeat_nr, release_nr, any_nr;

  int errors = 0;
  int checks = 0;

  // exp is {held, press, repeat, release}; any_event is derived from it
  typedef struct {
    string      name;
    logic       lvl;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  key_repeat_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk           (clk),
    .reset_low     (reset_low),
    .level         (level),
    .held          (held),
    .press         (press),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .any_event     (any_event)
  );

  key_repeat_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (0),
    .REPEAT_RATE     (3)
  ) dut_nr (
    .clk           (clk),
    .reset_low     (reset_low),
    .level         (level_nr),
    .held          (held_nr),
    .press         (press_nr),
    .repeat_pulse  (repeat_nr),
    .release_pulse (release_nr),
    .any_event     (any_nr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] withAny(input logic [3:0] e);
    return {e, |e[2:0]};
  endfunction

  function automatic void addVec(input string name, input logic lvl,
                                 input logic [3:0] exp, input int n);
    vec_t v;
    v.name = name;
    v.lvl  = lvl;
    v.exp  = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic lvl);
    @(negedge clk);
    level = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] expv);
    logic [4:0] act;
    act = {held, press, repeat_pulse, release_pulse, any_event};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: held/press/repeat/release/any got %b expected %b",
               name, act, expv);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  initial begin
    int press_cnt;
    int repeat_cnt;
    int release_cnt;

    reset_low = 1'b0;
    level     = 1'b0;
    level_nr  = 1'b0;

    // Reset held for three cycles while level toggles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(~level);
      checkOutput($sformatf("reset_cycle%0d", i), 5'b00000);
    end
    @(negedge clk);
    reset_low = 1'b1;
    level     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 5'b00000);

    // Clean press, three repeats at +10/+13/+16, then bouncy release
    addVec("clean",      1'b1, 4'b0000, 3);
    addVec("clean",      1'b1, 4'b1100, 1);
    addVec("clean",      1'b1, 4'b1000, 9);
    addVec("rep1",       1'b1, 4'b1010, 1);
    addVec("clean",      1'b1, 4'b1000, 2);
    addVec("rep2",       1'b1, 4'b1010, 1);
    addVec("clean",      1'b1, 4'b1000, 2);
    addVec("rep3",       1'b1, 4'b1010, 1);
    addVec("relbounce",  1'b0, 4'b1000, 2);
    addVec("relbounce",  1'b1, 4'b1000, 1);
    addVec("relbounce",  1'b0, 4'b1000, 3);
    addVec("release1",   1'b0, 4'b0001, 1);
    addVec("idle",       1'b0, 4'b0000, 1);
    // Press bounce rejected, then press on 4th HIGH of the final run
    addVec("bounce",     1'b1, 4'b0000, 2);
    addVec("bounce",     1'b0, 4'b0000, 1);
    addVec("bounce",     1'b1, 4'b0000, 3);
    addVec("press2",     1'b1, 4'b1100, 1);
    addVec("release",    1'b0, 4'b1000, 3);
    addVec("release2",   1'b0, 4'b0001, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].lvl);
      checkOutput($sformatf("%s[%0d]", vecs[i].name, i), withAny(vecs[i].exp));
    end

    // REPEAT_DELAY = 0: long hold gives one press and no repeats
    press_cnt   = 0;
    repeat_cnt  = 0;
    release_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      level_nr = 1'b1;
      @(posedge clk);
      #1;
      press_cnt   += int'(press_nr);
      repeat_cnt  += int'(repeat_nr);
      release_cnt += int'(release_nr);
    end
    checkCount("nr_held_during_hold", int'(held_nr), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      level_nr = 1'b0;
      @(posedge clk);
      #1;
      press_cnt   += int'(press_nr);
      repeat_cnt  += int'(repeat_nr);
      release_cnt += int'(release_nr);
    end
    checkCount("nr_press_count",   press_cnt,   1);
    checkCount("nr_repeat_count",  repeat_cnt,  0);
    checkCount("nr_release_count", release_cnt, 1);
    checkCount("nr_held_after",    int'(held_nr), 0);

    // Reset asserted mid-repeat with the key still down
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1);
      if (i == 13) checkOutput("mid_first_repeat", withAny(4'b1010));
      if (i == 14) checkOutput("mid_hold_repeat",  withAny(4'b1000));
    end
    #2;
    reset_low = 1'b0;
    #1;
    checkOutput("async_reset", 5'b00000);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("in_reset%0d", i), 5'b00000);
    end
    @(negedge clk);
    reset_low = 1'b1;
    level     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("redebounce0", 5'b00000);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("redebounce%0d", i), 5'b00000);
    end
    applyStimulus(1'b1);
    checkOutput("fresh_press", withAny(4'b1100));

    @(negedge clk);
    level = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
